// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings: writeback result-source select and register-file index constants.
package riscv_pkg;

  localparam int         REG_ADDR_W = 5;
  localparam logic [4:0] X0_IDX     = 5'd0;

  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_MEM  = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_RSVD = 2'b11
  } result_src_e;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result selector; purely combinational so the forwarding unit sees it in the same cycle.
module wb_result_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      result_src,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = alu_result;
    case (result_src_e'(result_src))
      RESULT_ALU:  result = alu_result;
      RESULT_MEM:  result = mem_data;
      RESULT_PC4:  result = pc_plus4;
      // reserved encoding falls back to the ALU path
      RESULT_RSVD: result = alu_result;
      default:     result = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Integer register file with writeback result mux, same-cycle write-to-read bypass and a committed-write counter.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       PC_plus4_In,
  input  logic [XLEN-1:0]       Read_Data_In,
  input  logic [XLEN-1:0]       ALU_Result_In,
  input  logic [REG_ADDR_W-1:0] Rd_In,
  input  logic                  Reg_write_In,
  input  logic [1:0]            ResultSrc_In,
  input  logic [REG_ADDR_W-1:0] Rs1_Addr,
  input  logic [REG_ADDR_W-1:0] Rs2_Addr,
  output logic [XLEN-1:0]       Rs1_Data,
  output logic [XLEN-1:0]       Rs2_Data,
  output logic [XLEN-1:0]       Wb_Result,
  output logic [31:0]           Wr_Count
);

  // x0 is hardwired, so only x1..x(NREG-1) are stored
  logic [XLEN-1:0] regs [1:NREG-1];
  logic [31:0]     wr_count_q;
  logic            wr_en;

  function automatic logic addr_stored(input logic [REG_ADDR_W-1:0] addr);
    return (addr != X0_IDX) && (int'(addr) < NREG);
  endfunction

  wb_result_mux #(
    .XLEN(XLEN)
  ) u_result_mux (
    .result_src(ResultSrc_In),
    .alu_result(ALU_Result_In),
    .mem_data  (Read_Data_In),
    .pc_plus4  (PC_plus4_In),
    .result    (Wb_Result)
  );

  assign wr_en = Reg_write_In && addr_stored(Rd_In);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[Rd_In] <= Wb_Result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_q <= '0;
    end else if (wr_en) begin
      wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign Wr_Count = wr_count_q;

  // Read ports are forced to zero while reset is held; bypass takes priority over the array.
  always_comb begin
    Rs1_Data = '0;
    if (reset) begin
      if (wr_en && (Rs1_Addr == Rd_In)) begin
        Rs1_Data = Wb_Result;
      end else if (addr_stored(Rs1_Addr)) begin
        Rs1_Data = regs[Rs1_Addr];
      end
    end
  end

  always_comb begin
    Rs2_Data = '0;
    if (reset) begin
      if (wr_en && (Rs2_Addr == Rd_In)) begin
        Rs2_Data = Wb_Result;
      end else if (addr_stored(Rs2_Addr)) begin
        Rs2_Data = regs[Rs2_Addr];
      end
    end
  end

endmodule
